// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote at mid-bit,
// back-to-back frames, frame-error detection and break handling.
module uart_rx_oversample #(
  parameter int DIV = 27
) (
  input  logic       clk50m,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rxdata,
  output logic       dataok,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state;
  logic            rx_meta, rxs;
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic [3:0]      scnt;
  logic [2:0]      bidx;
  logic [7:0]      shreg;
  logic            s7, s8;
  logic            vote;
  logic            mid, last;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign tick = (tcnt == TW'(DIV - 1));
  // third sample is the live rxs at the count-9 tick
  assign vote = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign mid  = tick && (scnt == 4'd9);
  assign last = tick && (scnt == 4'd15);

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      scnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      s7        <= 1'b0;
      s8        <= 1'b0;
      rxdata    <= '0;
      dataok    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dataok    <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || state == BREAK) begin
        tcnt <= '0;
      end else begin
        tcnt <= tick ? '0 : tcnt + TW'(1);
        if (tick) begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd7) s7 <= rxs;
          if (scnt == 4'd8) s8 <= rxs;
        end
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            busy  <= 1'b1;
            scnt  <= '0;
          end
        end
        START: begin
          if (mid && vote) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= DATA;
            bidx  <= '0;
          end
        end
        DATA: begin
          if (mid) shreg <= {vote, shreg[7:1]};
          if (last) begin
            if (bidx == 3'd7) state <= STOP;
            else              bidx  <= bidx + 3'd1;
          end
        end
        STOP: begin
          // leave at mid-stop so a following start edge is caught without a gap
          if (mid) begin
            if (vote) begin
              rxdata <= shreg;
              dataok <= 1'b1;
              state  <= IDLE;
              busy   <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at DIV=4 (64 clocks per bit).
module tb_uart_rx_oversample;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk50m = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rxdata;
  logic       dataok, frame_err, busy;

  uart_rx_oversample #(.DIV(DIV)) dut (
    .clk50m   (clk50m),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rxdata   (rxdata),
    .dataok   (dataok),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk50m = ~clk50m;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int fe_cnt = 0;
  int ok_cyc = 0;
  int viol = 0;
  logic [7:0] ok_data[$];
  logic       dataok_q = 1'b0;
  logic       fe_q = 1'b0;
  logic [7:0] rxdata_q = 8'h00;

  always @(posedge clk50m) cyc <= cyc + 1;

  // protocol monitor: pulse widths, exclusivity, rxdata stability
  always @(negedge clk50m) begin
    if (dataok) begin
      ok_cnt <= ok_cnt + 1;
      ok_cyc <= cyc;
      ok_data.push_back(rxdata);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    viol <= viol + int'(dataok && dataok_q) + int'(frame_err && fe_q)
                 + int'(dataok && frame_err)
                 + int'(reset_n && (rxdata !== rxdata_q) && !dataok);
    dataok_q <= dataok;
    fe_q     <= frame_err;
    rxdata_q <= rxdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk50m);
  endtask

  // start bit, 8 data bits LSB first, stop bit; optional 2-clock glitch mid-bit
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int gbit);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk50m);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == gbit) begin
        repeat (BIT / 2) @(negedge clk50m);
        rxd = ~d[i];
        repeat (2) @(negedge clk50m);
        rxd = d[i];
        repeat (BIT / 2 - 2) @(negedge clk50m);
      end else begin
        repeat (BIT) @(negedge clk50m);
      end
    end
    rxd = stopb;
    repeat (BIT) @(negedge clk50m);
    rxd = 1'b1;
  endtask

  initial begin
    int base_ok, base_fe, t0, lat;
    logic [7:0] d81;

    repeat (3) @(negedge clk50m);
    chk("rst_rxdata", rxdata, 8'h00);
    chk("rst_dataok", dataok, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    idle(5);
    chk("idle_busy", busy, 1'b0);

    // 0x55 good frame, latency ~9.5 bit periods
    base_ok = ok_cnt; base_fe = fe_cnt; t0 = cyc;
    send_frame(8'h55, 1'b1, -1);
    idle(20);
    chk("f55_ok_cnt", ok_cnt - base_ok, 1);
    chk("f55_fe_cnt", fe_cnt - base_fe, 0);
    chk("f55_rxdata", rxdata, 8'h55);
    lat = ok_cyc - t0;
    chk("f55_latency_window", (lat >= 600 && lat <= 640), 1'b1);
    chk("f55_busy_after", busy, 1'b0);

    // 0xA3 with bad stop bit, then 0x0F
    base_ok = ok_cnt; base_fe = fe_cnt;
    send_frame(8'hA3, 1'b0, -1);
    idle(20);
    chk("fA3_fe_cnt", fe_cnt - base_fe, 1);
    chk("fA3_ok_cnt", ok_cnt - base_ok, 0);
    chk("fA3_rxdata_held", rxdata, 8'h55);
    chk("fA3_busy_after", busy, 1'b0);
    base_ok = ok_cnt;
    send_frame(8'h0F, 1'b1, -1);
    idle(20);
    chk("f0F_ok_cnt", ok_cnt - base_ok, 1);
    chk("f0F_rxdata", rxdata, 8'h0F);

    // false start: 20 clocks low
    base_ok = ok_cnt; base_fe = fe_cnt;
    rxd = 1'b0;
    repeat (20) @(negedge clk50m);
    rxd = 1'b1;
    for (int w = 0; w < BIT && busy; w++) @(negedge clk50m);
    chk("false_start_busy", busy, 1'b0);
    idle(BIT);
    chk("false_start_ok", ok_cnt - base_ok, 0);
    chk("false_start_fe", fe_cnt - base_fe, 0);
    chk("false_start_rxdata", rxdata, 8'h0F);

    // glitch on data bit 3 rejected by majority
    base_ok = ok_cnt;
    send_frame(8'hC6, 1'b1, 3);
    idle(20);
    chk("glitch_ok_cnt", ok_cnt - base_ok, 1);
    chk("glitch_rxdata", rxdata, 8'hC6);

    // back-to-back 0x00, 0xFF
    base_ok = ok_cnt; base_fe = fe_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(20);
    chk("b2b_ok_cnt", ok_cnt - base_ok, 2);
    chk("b2b_fe_cnt", fe_cnt - base_fe, 0);
    chk("b2b_first", ok_data[base_ok], 8'h00);
    chk("b2b_second", ok_data[base_ok + 1], 8'hFF);

    // reset during bit 4 of 0x81
    base_ok = ok_cnt; base_fe = fe_cnt;
    d81 = 8'h81;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk50m);
    for (int i = 0; i < 4; i++) begin
      rxd = d81[i];
      repeat (BIT) @(negedge clk50m);
    end
    rxd = d81[4];
    repeat (BIT / 2) @(negedge clk50m);
    chk("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_rxdata", rxdata, 8'h00);
    chk("mid_reset_dataok", dataok, 1'b0);
    chk("mid_reset_frame_err", frame_err, 1'b0);
    rxd = 1'b1;
    repeat (3) @(negedge clk50m);
    reset_n = 1'b1;
    idle(2 * BIT);
    chk("post_reset_ok", ok_cnt - base_ok, 0);
    chk("post_reset_fe", fe_cnt - base_fe, 0);
    chk("post_reset_rxdata", rxdata, 8'h00);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);
    chk("f3C_ok_cnt", ok_cnt - base_ok, 1);
    chk("f3C_rxdata", rxdata, 8'h3C);

    chk("protocol_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
